// File: rtl/uart_pkg.sv
// Shared UART types, constants and the baud divisor helper.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package uart_pkg;

    localparam int unsigned UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_BREAK
    } uart_rx_state_t;

    // Clocks per oversample tick, rounded to the nearest integer.
    function automatic int unsigned uart_div(input int unsigned clock_freq,
                                             input int unsigned baud,
                                             input int unsigned os);
        int unsigned den;
        den = baud * os;
        return (clock_freq + (den >> 1)) / den;
    endfunction

endpackage

// File: rtl/uart_rx_oversample_if.sv
// Receive-side UART signals: serial line in, byte/status out.
// Latency: none (wiring only).
// Backpressure: none; the receiver pulses valid once per byte and the sink must take it.
interface uart_rx_oversample_if;
    import uart_pkg::*;

    logic                      uart_rx_d_in;
    logic [UART_DATA_BITS-1:0] uart_received_data;
    logic                      uart_rx_valid;
    logic                      uart_frame_error;
    logic                      uart_rx_busy;

    // Receiver side: samples the line, produces bytes and status.
    modport master (
        input  uart_rx_d_in,
        output uart_received_data,
        output uart_rx_valid,
        output uart_frame_error,
        output uart_rx_busy
    );

    // Line driver / byte consumer side.
    modport slave (
        output uart_rx_d_in,
        input  uart_received_data,
        input  uart_rx_valid,
        input  uart_frame_error,
        input  uart_rx_busy
    );

endinterface

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick generator: one-clk tick every DIV clocks.
// Latency: restart takes effect next clk; first tick DIV clks after restart.
// Backpressure: none; restart suppresses the current tick and realigns the phase.
module uart_baud_tick #(
    parameter int unsigned DIV = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic tick
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: clear on restart or wrap, otherwise increment.
    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (restart || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    assign tick = !restart && (cnt_q == LAST);

    // Divider counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx_oversample.sv
// 8N1 UART receiver: oversampled line, 3-sample mid-bit majority vote, glitch reject, stop check.
// Latency: valid/frame_error pulse ~2 sync clks + 1 tick after mid-stop-bit.
// Backpressure: none; one-clk valid per good byte, data held until the next good byte.
module uart_rx_oversample
    import uart_pkg::*;
#(
    parameter logic [25:0] CLOCK_FREQ = 26'd50000000,
    parameter logic [23:0] BAUD_RATE  = 24'd9600,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    uart_rx_oversample_if.master rx_if
);

    localparam int unsigned DIV = uart_div(32'(CLOCK_FREQ), 32'(BAUD_RATE), OVERSAMPLE);
    localparam int unsigned SW  = $clog2(OVERSAMPLE);
    localparam logic [SW-1:0] S_V0   = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_V1   = SW'(OVERSAMPLE / 2);
    localparam logic [SW-1:0] S_V2   = SW'(OVERSAMPLE / 2 + 1);
    localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [2:0]    IDX_LAST = 3'(UART_DATA_BITS - 1);

    logic sync1_q, sync2_q, sync3_q;
    logic rx_s;
    logic fall;

    uart_rx_state_t            state_q, state_d;
    logic [SW-1:0]             s_q, s_d;
    logic [SW-1:0]             s_next;
    logic [2:0]                bit_idx_q, bit_idx_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic                      v0_q, v0_d;
    logic                      v1_q, v1_d;
    logic [UART_DATA_BITS-1:0] data_q, data_d;
    logic                      valid_q, valid_d;
    logic                      ferr_q, ferr_d;
    logic                      restart;
    logic                      tick;
    logic                      vote;
    logic                      at_vote;

    uart_baud_tick #(.DIV(DIV)) u_tick (
        .clk     (clk),
        .reset   (reset),
        .restart (restart),
        .tick    (tick)
    );

    assign rx_s    = sync2_q;
    assign fall    = sync3_q & ~sync2_q;
    assign vote    = (v0_q & v1_q) | (v0_q & rx_s) | (v1_q & rx_s);
    assign at_vote = tick && (s_q == S_V2);
    assign s_next  = (s_q == S_LAST) ? '0 : s_q + SW'(1);

    // Two-flop synchroniser plus a third flop for falling-edge detection; idles high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            sync3_q <= 1'b1;
        end else begin
            sync1_q <= rx_if.uart_rx_d_in;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    // Next-state, sampling and output-pulse logic.
    always_comb begin
        state_d   = state_q;
        s_d       = s_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        v0_d      = v0_q;
        v1_d      = v1_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;
        restart   = 1'b0;

        // Within a frame, s tracks the tick position inside the current bit.
        if ((state_q == RX_START || state_q == RX_DATA || state_q == RX_STOP) && tick) begin
            s_d = s_next;
            if (s_q == S_V0) v0_d = rx_s;
            if (s_q == S_V1) v1_d = rx_s;
        end

        case (state_q)
            RX_IDLE: begin
                s_d = '0;
                if (fall) begin
                    restart   = 1'b1;
                    bit_idx_d = '0;
                    state_d   = RX_START;
                end
            end
            RX_START: begin
                if (at_vote) begin
                    if (vote) begin
                        state_d = RX_IDLE;
                    end else begin
                        bit_idx_d = '0;
                        state_d   = RX_DATA;
                    end
                end
            end
            RX_DATA: begin
                if (at_vote) begin
                    shift_d = {vote, shift_q[UART_DATA_BITS-1:1]};
                    if (bit_idx_q == IDX_LAST) begin
                        state_d = RX_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            RX_STOP: begin
                if (at_vote) begin
                    if (vote) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = RX_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        s_d     = '0;
                        state_d = RX_BREAK;
                    end
                end
            end
            RX_BREAK: begin
                // Count consecutive high ticks; any low clock restarts the bit-time wait.
                if (!rx_s) begin
                    s_d = '0;
                end else if (tick) begin
                    if (s_q == S_LAST) begin
                        s_d     = '0;
                        state_d = RX_IDLE;
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            default: begin
                state_d = RX_IDLE;
                s_d     = '0;
            end
        endcase
    end

    // FSM, datapath and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= RX_IDLE;
            s_q       <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            v0_q      <= 1'b0;
            v1_q      <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            s_q       <= s_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            v0_q      <= v0_d;
            v1_q      <= v1_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
        end
    end

    assign rx_if.uart_received_data = data_q;
    assign rx_if.uart_rx_valid      = valid_q;
    assign rx_if.uart_frame_error   = ferr_q;
    assign rx_if.uart_rx_busy       = (state_q != RX_IDLE);

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Bench for uart_rx_oversample: directed frames at 160 clk/bit.
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_rx_oversample;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    uart_rx_oversample_if rx_if();

    uart_rx_oversample #(
        .CLOCK_FREQ (26'd1600000),
        .BAUD_RATE  (24'd10000),
        .OVERSAMPLE (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .rx_if (rx_if)
    );

    int checks = 0;
    int errors = 0;
    int n_valid = 0;
    int n_err = 0;
    logic [7:0] vlog[$];

    typedef struct {
        logic [7:0] d;
        logic       stop_b;
        int         gap;
        int         dv;
        int         de;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Pulse monitor: counts valid/frame_error pulses and logs received bytes.
    always @(negedge clk) begin
        if (!reset && (rx_if.uart_rx_valid || rx_if.uart_frame_error)) begin
            if (rx_if.uart_rx_valid) begin
                n_valid++;
                vlog.push_back(rx_if.uart_received_data);
            end
            if (rx_if.uart_frame_error) n_err++;
            check("valid_ferr_exclusive", 32'(rx_if.uart_rx_valid & rx_if.uart_frame_error), 32'd0);
        end
    end

    task automatic hold(input logic v, input int n);
        rx_if.uart_rx_d_in = v;
        repeat (n) @(negedge clk);
    endtask

    // Drive one 8N1 frame; glitch_bit >= 0 inverts that data bit for one tick around its centre.
    task automatic send_frame(input logic [7:0] d, input logic stop_b, input int glitch_bit);
        int lat;
        hold(1'b0, 160);
        for (int b = 0; b < 8; b++) begin
            if (b == glitch_bit) begin
                hold(d[b], 88);
                hold(~d[b], 10);
                hold(d[b], 62);
            end else begin
                hold(d[b], 160);
            end
        end
        hold(stop_b, 80);
        if (stop_b) begin
            lat = -1;
            for (int i = 0; i < 80; i++) begin
                @(negedge clk);
                if (lat < 0 && !rx_if.uart_rx_busy) lat = i;
            end
            check("busy_drop_after_mid_stop", 32'(lat >= 0 && lat < 90), 32'd1);
        end else begin
            hold(stop_b, 80);
        end
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pv, pe, t;
        logic [7:0] last_exp;

        vecs[0] = '{8'hA5, 1'b1, 200, 1, 0, 8'hA5};
        vecs[1] = '{8'h3C, 1'b0, 400, 0, 1, 8'hA5};
        vecs[2] = '{8'h5A, 1'b1, 200, 1, 0, 8'h5A};
        vecs[3] = '{8'hC3, 1'b1, 200, 1, 0, 8'hC3};
        vecs[4] = '{8'h01, 1'b1, 200, 1, 0, 8'h01};
        vecs[5] = '{8'h80, 1'b1, 200, 1, 0, 8'h80};

        // Reset state
        reset = 1'b1;
        rx_if.uart_rx_d_in = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_data",  32'(rx_if.uart_received_data), 32'h00);
        check("reset_valid", 32'(rx_if.uart_rx_valid), 32'd0);
        check("reset_ferr",  32'(rx_if.uart_frame_error), 32'd0);
        check("reset_busy",  32'(rx_if.uart_rx_busy), 32'd0);
        reset = 1'b0;
        hold(1'b1, 50);

        // Table-driven frames
        last_exp = 8'h00;
        for (int i = 0; i < 6; i++) begin
            pv = n_valid;
            pe = n_err;
            send_frame(vecs[i].d, vecs[i].stop_b, -1);
            hold(1'b1, vecs[i].gap);
            check("vec_valid_count", 32'(n_valid - pv), 32'(vecs[i].dv));
            check("vec_ferr_count",  32'(n_err - pe),   32'(vecs[i].de));
            check("vec_data",        32'(rx_if.uart_received_data), 32'(vecs[i].exp_data));
            check("vec_idle_busy",   32'(rx_if.uart_rx_busy), 32'd0);
            last_exp = vecs[i].exp_data;
        end

        // Start-bit glitch of 30 clk
        pv = n_valid;
        pe = n_err;
        hold(1'b0, 30);
        rx_if.uart_rx_d_in = 1'b1;
        t = 30;
        while (rx_if.uart_rx_busy && t < 230) begin
            @(negedge clk);
            t++;
        end
        check("glitch_busy_drop_by_start_sample", 32'(t <= 110), 32'd1);
        hold(1'b1, 200);
        check("glitch_no_valid", 32'(n_valid - pv), 32'd0);
        check("glitch_no_ferr",  32'(n_err - pe),   32'd0);

        // Bad stop bit, then line held low 500 clk
        pv = n_valid;
        pe = n_err;
        send_frame(8'h3C, 1'b0, -1);
        hold(1'b0, 500);
        check("held_low_one_ferr", 32'(n_err - pe),   32'd1);
        check("held_low_no_valid", 32'(n_valid - pv), 32'd0);
        check("held_low_data",     32'(rx_if.uart_received_data), 32'(last_exp));
        hold(1'b1, 100);
        check("break_busy_at_100", 32'(rx_if.uart_rx_busy), 32'd1);
        hold(1'b1, 100);
        check("break_idle_at_200", 32'(rx_if.uart_rx_busy), 32'd0);
        pv = n_valid;
        send_frame(8'h6E, 1'b1, -1);
        hold(1'b1, 200);
        check("after_break_valid", 32'(n_valid - pv), 32'd1);
        check("after_break_data",  32'(rx_if.uart_received_data), 32'h6E);

        // Back-to-back 0x00 then 0xFF, single stop bit
        pv = n_valid;
        vlog.delete();
        send_frame(8'h00, 1'b1, -1);
        send_frame(8'hFF, 1'b1, -1);
        hold(1'b1, 200);
        check("b2b_valid_count", 32'(n_valid - pv), 32'd2);
        check("b2b_first",  32'((vlog.size() > 0) ? vlog[0] : 8'hXX), 32'h00);
        check("b2b_second", 32'((vlog.size() > 1) ? vlog[1] : 8'hXX), 32'hFF);

        // One-tick inversion at the centre of data bit 3
        pv = n_valid;
        send_frame(8'h5A, 1'b1, 3);
        hold(1'b1, 200);
        check("majority_valid", 32'(n_valid - pv), 32'd1);
        check("majority_data",  32'(rx_if.uart_received_data), 32'h5A);

        // Reset during data bit 4 of 0x77
        hold(1'b0, 160);
        for (int b = 0; b < 4; b++) hold(1'b1 & (8'h77 >> b), 160);
        hold(1'b1, 80);
        reset = 1'b1;
        #1;
        check("midreset_data",  32'(rx_if.uart_received_data), 32'h00);
        check("midreset_valid", 32'(rx_if.uart_rx_valid), 32'd0);
        check("midreset_ferr",  32'(rx_if.uart_frame_error), 32'd0);
        check("midreset_busy",  32'(rx_if.uart_rx_busy), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        hold(1'b1, 300);
        pv = n_valid;
        pe = n_err;
        send_frame(8'h12, 1'b1, -1);
        hold(1'b1, 200);
        check("post_reset_valid", 32'(n_valid - pv), 32'd1);
        check("post_reset_ferr",  32'(n_err - pe),   32'd0);
        check("post_reset_data",  32'(rx_if.uart_received_data), 32'h12);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
